// File: rtl/vec_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_mac_pkg
// Description : Shared defaults, state encoding and saturation-limit helpers
//               for the vec_mac dot-product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_mac_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ACC_W  = 32;

  // Wide carrier for limit constants; any ACC_W up to 126 bits fits.
  localparam int LIM_W = 128;
  typedef logic signed [LIM_W-1:0] lim_t;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Guard bits above max(ACC_W, 2*DATA_W): clog2(LANES) for the adder tree,
  // one for the accumulator add and one so unsigned values stay positive
  // when viewed as signed.
  function automatic int guard_w(input int lanes);
    return $clog2(lanes) + 2;
  endfunction

  // Largest representable accumulator value for width w.
  function automatic lim_t sat_max(input int w, input logic is_signed);
    return is_signed ? (lim_t'(1) <<< (w - 1)) - lim_t'(1)
                     : (lim_t'(1) <<< w) - lim_t'(1);
  endfunction

  // Smallest representable accumulator value for width w.
  function automatic lim_t sat_min(input int w, input logic is_signed);
    return is_signed ? -(lim_t'(1) <<< (w - 1)) : lim_t'(0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : vec_mac_lane
// Description : One registered DATA_W x DATA_W multiplier. Produces the full
//               2*DATA_W product, signed or unsigned per signed_mode.
// Ports       : clk, reset (sync, active-low), clear (sync flush),
//               en (load product), signed_mode, a, b, prod (registered).
// Revision    : 1.0 - initial release
// ============================================================================
module vec_mac_lane
  import vec_mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  signed_mode,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   prod
);

  logic [2*DATA_W-1:0] w_a_ext;
  logic [2*DATA_W-1:0] w_b_ext;

  // Extending both operands to the product width makes the truncated
  // 2*DATA_W product exact for either interpretation.
  assign w_a_ext = signed_mode ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
  assign w_b_ext = signed_mode ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      prod <= '0;
    end else if (en) begin
      prod <= w_a_ext * w_b_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vec_mac.sv
`default_nettype none
// ============================================================================
// Module      : vec_mac
// Description : Pipelined multi-lane dot-product accumulator with optional
//               saturation and sticky overflow flag.
// Ports       : clk, reset (sync, active-low), clear (sync flush),
//               signed_mode, sat_en (latched on first beat of a vector),
//               in_valid/in_ready, a_in/b_in (lane 0 in LSBs), in_last,
//               out_valid/out_ready, accum_out, ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_mac
  import vec_mac_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      signed_mode,
  input  logic                      sat_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   a_in,
  input  logic [LANES*DATA_W-1:0]   b_in,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          accum_out,
  output logic                      ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int BASE_W = (ACC_W > PROD_W) ? ACC_W : PROD_W;
  localparam int SUM_W  = BASE_W + guard_w(LANES);

  localparam logic signed [SUM_W-1:0] S_MAX = SUM_W'(sat_max(ACC_W, 1'b1));
  localparam logic signed [SUM_W-1:0] S_MIN = SUM_W'(sat_min(ACC_W, 1'b1));
  localparam logic signed [SUM_W-1:0] U_MAX = SUM_W'(sat_max(ACC_W, 1'b0));
  localparam logic signed [SUM_W-1:0] U_MIN = SUM_W'(sat_min(ACC_W, 1'b0));

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_first;     // next accepted beat starts a vector
  logic                r_signed;
  logic                r_sat;
  logic                r_p_valid;   // stage-1 products hold a beat
  logic                r_p_last;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;

  logic                w_accept;
  logic                w_lane_signed;
  logic [PROD_W-1:0]   w_prod [LANES];

  logic signed [SUM_W-1:0] w_psum;
  logic signed [SUM_W-1:0] w_acc_ext;
  logic signed [SUM_W-1:0] w_total;
  logic signed [SUM_W-1:0] w_lim_hi;
  logic signed [SUM_W-1:0] w_lim_lo;
  logic                    w_over;
  logic                    w_under;
  logic [ACC_W-1:0]        w_acc_nxt;

  assign w_accept = in_valid && in_ready && !clear;
  // The first beat multiplies under the mode being latched at that edge.
  assign w_lane_signed = r_first ? signed_mode : r_signed;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_mac_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .en          (w_accept),
      .signed_mode (w_lane_signed),
      .a           (a_in[i*DATA_W +: DATA_W]),
      .b           (b_in[i*DATA_W +: DATA_W]),
      .prod        (w_prod[i])
    );
  end

  // Adder tree over lane products, extended per the latched mode.
  always_comb begin
    w_psum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_signed) begin
        w_psum = w_psum + {{(SUM_W-PROD_W){w_prod[i][PROD_W-1]}}, w_prod[i]};
      end else begin
        w_psum = w_psum + {{(SUM_W-PROD_W){1'b0}}, w_prod[i]};
      end
    end
  end

  assign w_acc_ext = r_signed ? {{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc}
                              : {{(SUM_W-ACC_W){1'b0}}, r_acc};
  assign w_total   = w_acc_ext + w_psum;
  assign w_lim_hi  = r_signed ? S_MAX : U_MAX;
  assign w_lim_lo  = r_signed ? S_MIN : U_MIN;
  assign w_over    = w_total > w_lim_hi;
  assign w_under   = w_total < w_lim_lo;

  always_comb begin
    w_acc_nxt = w_total[ACC_W-1:0];
    if (r_sat && w_over) begin
      w_acc_nxt = w_lim_hi[ACC_W-1:0];
    end else if (r_sat && w_under) begin
      w_acc_nxt = w_lim_lo[ACC_W-1:0];
    end
  end

  // Handshake FSM: state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake FSM: next state and outputs.
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        // Drop ready once a last beat sits in stage 1.
        in_ready = !(r_p_valid && r_p_last);
        if (r_p_valid && r_p_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
    if (clear) begin
      w_state_nxt = ST_ACCUM;
    end
  end

  // Stage 2 accumulator, mode latches and stage-1 tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_first   <= 1'b1;
      r_signed  <= 1'b0;
      r_sat     <= 1'b0;
      r_p_valid <= 1'b0;
      r_p_last  <= 1'b0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
    end else if (clear) begin
      r_first   <= 1'b1;
      r_p_valid <= 1'b0;
      r_p_last  <= 1'b0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_p_valid <= w_accept;
      r_p_last  <= w_accept && in_last;
      if (w_accept) begin
        r_first <= in_last;
        if (r_first) begin
          r_signed <= signed_mode;
          r_sat    <= sat_en;
        end
      end
      if (r_state == ST_HOLD && out_ready) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (r_p_valid && !(r_sat && r_ovf)) begin
        // A saturated result stays clamped for the rest of the vector.
        r_acc <= w_acc_nxt;
        if (w_over || w_under) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign accum_out = r_acc;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_vec_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_mac
// Description : Self-checking bench for vec_mac (LANES=4, DATA_W=8,
//               ACC_W=16) with an integer reference model of the vector
//               accumulation and directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_mac;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     clear = 1'b0;
  logic                     signed_mode = 1'b0;
  logic                     sat_en = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [LANES*DATA_W-1:0]  a_in = '0;
  logic [LANES*DATA_W-1:0]  b_in = '0;
  logic                     in_last = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [ACC_W-1:0]         accum_out;
  logic                     ovf;

  vec_mac #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .signed_mode (signed_mode),
    .sat_en      (sat_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .accum_out   (accum_out),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: running true value of the current vector.
  longint      m_acc = 0;
  bit          m_ovf = 0;
  bit          m_first = 1;
  bit          m_signed = 0;
  bit          m_sat = 0;
  bit          exp_pending = 0;
  logic [15:0] exp_acc = '0;
  logic        exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint lane_val(input logic [7:0] v, input bit sg);
    return sg ? longint'($signed(v)) : longint'(v);
  endfunction

  task automatic model_reset(input bit full);
    m_acc = 0;
    m_ovf = 0;
    m_first = 1;
    exp_pending = 0;
    if (full) begin
      m_signed = 0;
      m_sat = 0;
    end
  endtask

  task automatic model_beat(input logic [31:0] a, input logic [31:0] b,
                            input bit last, input bit sm, input bit se);
    longint dot = 0;
    longint t;
    longint lo;
    longint hi;
    longint w;
    if (m_first) begin
      m_signed = sm;
      m_sat = se;
    end
    m_first = last;
    lo = m_signed ? -32768 : 0;
    hi = m_signed ? 32767 : 65535;
    for (int k = 0; k < LANES; k++) begin
      dot += lane_val(a[8*k +: 8], m_signed) * lane_val(b[8*k +: 8], m_signed);
    end
    if (!(m_sat && m_ovf)) begin
      t = m_acc + dot;
      if (t > hi || t < lo) begin
        m_ovf = 1;
        if (m_sat) begin
          m_acc = (t > hi) ? hi : lo;
        end else begin
          w = t & 64'hFFFF;
          if (m_signed && w > 32767) w -= 65536;
          m_acc = w;
        end
      end else begin
        m_acc = t;
      end
    end
    if (last) begin
      exp_acc = m_acc[15:0];
      exp_ovf = m_ovf;
      exp_pending = 1;
      m_acc = 0;
      m_ovf = 0;
    end
  endtask

  // Presents one beat, waits (bounded) for acceptance, updates the model.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input bit last, input bit sm, input bit se);
    int guard = 0;
    a_in = a;
    b_in = b;
    in_last = last;
    signed_mode = sm;
    sat_en = se;
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("beat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    model_beat(a, b, last, sm, se);
  endtask

  // Waits for the result, holds it for `hold` cycles, then handshakes.
  task automatic collect(input int hold, input string name,
                         input logic [15:0] lit_acc, input logic lit_ovf);
    int guard = 0;
    while (!out_valid && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_acc"}, accum_out, lit_acc);
    chk({name, "_ovf"}, ovf, lit_ovf);
    chk({name, "_model"}, exp_acc, lit_acc);
    repeat (hold) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_pending = 0;
    chk({name, "_done_valid"}, out_valid, 0);
    chk({name, "_done_rdy"}, in_ready, 1);
    chk({name, "_done_acc"}, accum_out, 0);
    chk({name, "_done_ovf"}, ovf, 0);
  endtask

  // Compare process: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_pending) begin
        chk("cmp_acc", accum_out, exp_acc);
        chk("cmp_ovf", ovf, exp_ovf);
        chk("cmp_in_ready", in_ready, 0);
      end else begin
        chk("cmp_spurious_valid", out_valid, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    model_reset(1);
    chk("rst_valid", out_valid, 0);
    chk("rst_acc", accum_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Unsigned single beat with latency check
    send_beat(32'h04030201, 32'h08070605, 1, 0, 0);
    chk("t1_lat_early", out_valid, 0);
    chk("t1_rdy_low", in_ready, 0);
    @(posedge clk); #1;
    chk("t1_lat", out_valid, 1);
    collect(0, "t1", 16'd70, 1'b0);

    // Three back-to-back beats
    send_beat(32'h04030201, 32'h08070605, 0, 0, 0);
    send_beat(32'h04030201, 32'h08070605, 0, 0, 0);
    send_beat(32'h04030201, 32'h08070605, 1, 0, 0);
    chk("t2_rdy_low", in_ready, 0);
    collect(1, "t2", 16'd210, 1'b0);

    // Signed -1 * 127 on all lanes
    send_beat(32'hFFFFFFFF, 32'h7F7F7F7F, 1, 1, 0);
    collect(0, "t3", 16'hFE04, 1'b0);

    // Unsigned overflow: saturate, then wrap
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1);
    collect(0, "t4_sat", 16'hFFFF, 1'b1);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0);
    collect(0, "t4_wrap", 16'd63492, 1'b1);

    // sat_en changed mid-vector is ignored
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1);
    send_beat(32'h04030201, 32'h08070605, 1, 0, 0);
    collect(0, "t4_tog_sat", 16'hFFFF, 1'b1);
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    send_beat(32'h04030201, 32'h08070605, 1, 1, 1);
    collect(0, "t4_tog_wrap", 16'd63562, 1'b1);

    // Signed saturation at both limits
    send_beat(32'h80808080, 32'h80808080, 1, 1, 1);
    collect(0, "t5_smax", 16'h7FFF, 1'b1);
    send_beat(32'h80808080, 32'h7F7F7F7F, 1, 1, 1);
    collect(0, "t5_smin", 16'h8000, 1'b1);
    send_beat(32'h80808080, 32'h80808080, 1, 1, 0);
    collect(0, "t5_swrap", 16'h0000, 1'b1);

    // Output held for 5 cycles
    send_beat(32'h04030201, 32'h08070605, 1, 0, 0);
    collect(5, "t6", 16'd70, 1'b0);

    // Clear after beat 1; a beat presented with clear is dropped
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    clear = 1'b1;
    in_valid = 1'b1;
    in_last = 1'b1;
    a_in = 32'h11111111;
    b_in = 32'h22222222;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    model_reset(0);
    chk("t7_rdy", in_ready, 1);
    chk("t7_valid", out_valid, 0);
    chk("t7_acc", accum_out, 0);
    chk("t7_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 chk("t7_no_accept", out_valid, 0);
    send_beat(32'h04030201, 32'h08070605, 1, 0, 0);
    collect(0, "t7", 16'd70, 1'b0);

    // Reset while holding a result
    send_beat(32'h04030201, 32'h08070605, 1, 0, 0);
    @(posedge clk); #1;
    chk("t8_hold", out_valid, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset(1);
    chk("t8_valid", out_valid, 0);
    chk("t8_acc", accum_out, 0);
    chk("t8_ovf", ovf, 0);
    chk("t8_rdy", in_ready, 1);
    send_beat(32'h05FC03FE, 32'h0A09F807, 1, 1, 0);
    collect(0, "t8", 16'hFFE8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
